// File: rtl/chunked_adder_if.sv
// rtl/chunked_adder_if.sv - operand/result handshake bundle for chunked_adder; sub present only with ADDER_SUB_EN
interface chunked_adder_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              carry_in;
`ifdef ADDER_SUB_EN
    logic              sub;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] sum;
    logic              carry_out;
    logic              overflow;
    logic              busy;

`ifdef ADDER_SUB_EN
    modport master (
        output req_valid, a, b, carry_in, sub, rsp_ready,
        input  req_ready, rsp_valid, sum, carry_out, overflow, busy
    );
    modport slave (
        input  req_valid, a, b, carry_in, sub, rsp_ready,
        output req_ready, rsp_valid, sum, carry_out, overflow, busy
    );
`else
    modport master (
        output req_valid, a, b, carry_in, rsp_ready,
        input  req_ready, rsp_valid, sum, carry_out, overflow, busy
    );
    modport slave (
        input  req_valid, a, b, carry_in, rsp_ready,
        output req_ready, rsp_valid, sum, carry_out, overflow, busy
    );
`endif
endinterface

// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle chunked adder, CHUNK_W bits per clock; ADDER_SUB_EN adds subtract mode
module chunked_adder #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    chunked_adder_if.slave  bus
);
    localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               carry_q;
    logic               ovf_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  sum_q;

    logic               op_sub;
    logic [DATA_W-1:0]  b_eff;
    logic               c0;
    logic               last_chunk;
    int                 lo;
    logic [CHUNK_W-1:0] chunk_a;
    logic [CHUNK_W-1:0] chunk_b;
    logic [CHUNK_W-1:0] chunk_sum;
    logic               chunk_carry;

`ifdef ADDER_SUB_EN
    assign op_sub = bus.sub;
`else
    assign op_sub = 1'b0;
`endif

    // Subtraction is A + ~B + ~borrow, so B and the carry-in are inverted once at accept
    assign b_eff      = op_sub ? ~bus.b : bus.b;
    assign c0         = bus.carry_in ^ op_sub;
    assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

    // One chunk slice of the stored operands plus the running carry
    always_comb begin
        lo        = int'(cnt) * CHUNK_W;
        chunk_a   = a_q[lo +: CHUNK_W];
        chunk_b   = b_q[lo +: CHUNK_W];
        {chunk_carry, chunk_sum} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK_W{1'b0}}, carry_q};
    end

    // Handshake FSM and chunk-serial datapath; outputs freeze in DONE until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_q     <= bus.a;
                        b_q     <= b_eff;
                        carry_q <= c0;
                        cnt     <= '0;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q[lo +: CHUNK_W] <= chunk_sum;
                    carry_q              <= chunk_carry;
                    cnt                  <= cnt + 1'b1;
                    if (last_chunk) begin
                        // Top chunk holds the sign bits of A, B' and the result
                        ovf_q <= (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                                 (chunk_sum[CHUNK_W-1] != a_q[DATA_W-1]);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.busy      = (state == BUSY);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
endmodule
